// File: rtl/opc8_arb_pkg.sv
// Shared types and widths for the opc8 CPU/DMA memory-port arbiter.
package opc8_arb_pkg;

  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 24;
  localparam int WAIT_W   = $clog2(8);
  localparam int STARVE_W = 8;
  localparam int BURST_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_BUS = 2'd1,
    DMA_BUS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/opc8_arb_pick.sv
// Winner select between CPU and DMA, with the anti-starvation counter that
// forces a DMA grant after STARVE_LIMIT contended CPU wins.
module opc8_arb_pick
  import opc8_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  input  logic i_grant_en,
  output logic o_cpu_win,
  output logic o_dma_win
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_forced;

  always_comb begin
    w_forced  = i_dma_req && (r_starve_cnt == LIMIT);
    o_cpu_win = i_cpu_req && !w_forced;
    o_dma_win = i_dma_req && !o_cpu_win;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_starve_cnt <= '0;
    end else if (i_grant_en) begin
      if (o_dma_win)
        r_starve_cnt <= '0;
      else if (o_cpu_win && i_dma_req && r_starve_cnt != LIMIT)
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/opc8_bus_arbiter.sv
// Shares one memory port between the opc8 CPU (paced by cpu_clken) and a DMA
// master. Optional DMA read bursts are enabled by OPC8_ARB_DMA_BURST_EN.
module opc8_bus_arbiter
  import opc8_arb_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              cpu_vpa,
  input  logic              cpu_vda,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_clken,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
`ifdef OPC8_ARB_DMA_BURST_EN
  input  logic              dma_burst,
`endif
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0]  LAST_WAIT = WAIT_W'(MEM_LAT - 1);
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);

  arb_state_e          r_state, w_next_state;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_burst;
  logic [BURST_W-1:0]  r_beat;

  logic w_cpu_req, w_cpu_win, w_dma_win, w_in_idle;
  logic w_done, w_burst_grant, w_next_beat;

  assign w_cpu_req = cpu_vpa | cpu_vda;
  assign w_in_idle = (r_state == IDLE);
  assign w_done    = !w_in_idle && (r_wait == LAST_WAIT);

`ifdef OPC8_ARB_DMA_BURST_EN
  assign w_burst_grant = dma_burst && dma_rnw;
`else
  assign w_burst_grant = 1'b0;
`endif

  // Another beat follows only while the requester keeps asking and the cap
  // has not been reached.
  assign w_next_beat = r_burst && dma_req && (r_beat != LAST_BEAT);

  opc8_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk        (clk),
    .reset_b    (reset_b),
    .i_cpu_req  (w_cpu_req),
    .i_dma_req  (dma_req),
    .i_grant_en (w_in_idle),
    .o_cpu_win  (w_cpu_win),
    .o_dma_win  (w_dma_win)
  );

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    w_next_state = r_state;
    cpu_clken    = 1'b0;
    dma_ack      = 1'b0;
    mem_ce       = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_clken = !w_cpu_req;
        if (w_cpu_win)      w_next_state = CPU_BUS;
        else if (w_dma_win) w_next_state = DMA_BUS;
      end
      CPU_BUS: begin
        mem_ce = (r_wait == '0);
        if (w_done) begin
          cpu_clken    = 1'b1;
          w_next_state = IDLE;
        end
      end
      DMA_BUS: begin
        mem_ce = (r_wait == '0);
        if (w_done) begin
          dma_ack = 1'b1;
          if (!w_next_beat) w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    // Reset aborts any access in flight and lets the CPU clock through.
    if (!reset_b) begin
      cpu_clken = 1'b1;
      dma_ack   = 1'b0;
      mem_ce    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state       <= IDLE;
      r_wait        <= '0;
      r_mem_we      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_burst       <= 1'b0;
      r_beat        <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_in_idle) begin
        r_wait <= '0;
        if (w_cpu_win) begin
          r_mem_address <= cpu_address;
          r_mem_wdata   <= cpu_dout;
          r_mem_we      <= !cpu_rnw;
          r_burst       <= 1'b0;
        end else if (w_dma_win) begin
          r_mem_address <= dma_address;
          r_mem_wdata   <= dma_wdata;
          r_mem_we      <= !dma_rnw;
          r_burst       <= w_burst_grant;
          r_beat        <= '0;
        end
      end else if (w_done) begin
        r_wait <= '0;
        if (r_state == DMA_BUS && w_next_beat) begin
          r_mem_address <= r_mem_address + ADDR_W'(1);
          r_beat        <= r_beat + BURST_W'(1);
        end
      end else begin
        r_wait <= r_wait + WAIT_W'(1);
      end
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign cpu_din     = mem_rdata;
  assign dma_rdata   = mem_rdata;

endmodule

// File: tb/tb_opc8_bus_arbiter.sv
// Directed bench for opc8_bus_arbiter: one instance with MEM_LAT=1 and one
// with MEM_LAT=2; burst checks run when OPC8_ARB_DMA_BURST_EN is defined.
module tb_opc8_bus_arbiter;
  import opc8_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: MEM_LAT=1, STARVE_LIMIT=4
  logic        a_reset_b, a_vpa, a_vda, a_rnw, a_clken;
  logic [23:0] a_addr, a_dout, a_din;
  logic        a_dreq, a_drnw, a_dack;
  logic [23:0] a_daddr, a_dwdata, a_drdata;
  logic        a_ce, a_we;
  logic [23:0] a_maddr, a_mwdata, a_mrdata;
`ifdef OPC8_ARB_DMA_BURST_EN
  logic        a_burst;
`endif

  // Instance B: MEM_LAT=2, STARVE_LIMIT=4
  logic        b_reset_b, b_vpa, b_vda, b_rnw, b_clken;
  logic [23:0] b_addr, b_dout, b_din;
  logic        b_dreq, b_drnw, b_dack;
  logic [23:0] b_daddr, b_dwdata, b_drdata;
  logic        b_ce, b_we;
  logic [23:0] b_maddr, b_mwdata, b_mrdata;
`ifdef OPC8_ARB_DMA_BURST_EN
  logic        b_burst;
`endif

  opc8_bus_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4), .MAX_BURST(16)) u_dut_a (
    .clk(clk), .reset_b(a_reset_b),
    .cpu_vpa(a_vpa), .cpu_vda(a_vda), .cpu_rnw(a_rnw),
    .cpu_address(a_addr), .cpu_dout(a_dout), .cpu_din(a_din), .cpu_clken(a_clken),
    .dma_req(a_dreq), .dma_rnw(a_drnw), .dma_address(a_daddr), .dma_wdata(a_dwdata),
`ifdef OPC8_ARB_DMA_BURST_EN
    .dma_burst(a_burst),
`endif
    .dma_ack(a_dack), .dma_rdata(a_drdata),
    .mem_ce(a_ce), .mem_we(a_we), .mem_address(a_maddr), .mem_wdata(a_mwdata),
    .mem_rdata(a_mrdata)
  );

  opc8_bus_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4), .MAX_BURST(16)) u_dut_b (
    .clk(clk), .reset_b(b_reset_b),
    .cpu_vpa(b_vpa), .cpu_vda(b_vda), .cpu_rnw(b_rnw),
    .cpu_address(b_addr), .cpu_dout(b_dout), .cpu_din(b_din), .cpu_clken(b_clken),
    .dma_req(b_dreq), .dma_rnw(b_drnw), .dma_address(b_daddr), .dma_wdata(b_dwdata),
`ifdef OPC8_ARB_DMA_BURST_EN
    .dma_burst(b_burst),
`endif
    .dma_ack(b_dack), .dma_rdata(b_drdata),
    .mem_ce(b_ce), .mem_we(b_we), .mem_address(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_mrdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_reset_b = 1'b0; a_vpa = 1'b0; a_vda = 1'b0; a_rnw = 1'b1;
    a_addr = '0; a_dout = '0; a_dreq = 1'b0; a_drnw = 1'b1;
    a_daddr = '0; a_dwdata = '0; a_mrdata = '0;
    b_reset_b = 1'b0; b_vpa = 1'b0; b_vda = 1'b0; b_rnw = 1'b1;
    b_addr = '0; b_dout = '0; b_dreq = 1'b0; b_drnw = 1'b1;
    b_daddr = '0; b_dwdata = '0; b_mrdata = '0;
`ifdef OPC8_ARB_DMA_BURST_EN
    a_burst = 1'b0; b_burst = 1'b0;
`endif

    // Reset state
    tick(); tick();
    check("rst_clken", a_clken, 1);
    check("rst_ce", a_ce, 0);
    check("rst_ack", a_dack, 0);
    check("rst_maddr", a_maddr, 0);
    a_reset_b = 1'b1; b_reset_b = 1'b1;
    #1;
    check("rst_we", a_we, 0);
    check("rst_mwdata", a_mwdata, 0);
    check("idle_clken", a_clken, 1);

    // CPU fetch at 000010, MEM_LAT=1: clken 0 then 1
    a_vpa = 1'b1; a_rnw = 1'b1; a_addr = 24'h000010; a_mrdata = 24'h123456;
    #1;
    check("fetch_idle_clken", a_clken, 0);
    check("fetch_idle_ce", a_ce, 0);
    tick();
    check("fetch_ce", a_ce, 1);
    check("fetch_maddr", a_maddr, 24'h000010);
    check("fetch_we", a_we, 0);
    check("fetch_clken", a_clken, 1);
    check("fetch_din", a_din, 24'h123456);
    tick();
    check("fetch2_idle_clken", a_clken, 0);
    a_vpa = 1'b0;
    #1;
    check("internal_clken", a_clken, 1);

    // CPU data write
    a_vda = 1'b1; a_rnw = 1'b0; a_addr = 24'h00ABC0; a_dout = 24'h55AA55;
    tick();
    check("cwr_we", a_we, 1);
    check("cwr_wdata", a_mwdata, 24'h55AA55);
    check("cwr_maddr", a_maddr, 24'h00ABC0);
    check("cwr_clken", a_clken, 1);
    a_vda = 1'b0; a_rnw = 1'b1;
    tick();
    check("cwr_done_ce", a_ce, 0);

    // CPU internal cycle with DMA request: clken=1 and DMA granted same edge
    a_dreq = 1'b1; a_drnw = 1'b1; a_daddr = 24'h000200; a_mrdata = 24'h0ABCDE;
    #1;
    check("int_dma_clken", a_clken, 1);
    tick();
    check("dma_rd_ack", a_dack, 1);
    check("dma_rd_maddr", a_maddr, 24'h000200);
    check("dma_rd_ce", a_ce, 1);
    check("dma_rd_clken", a_clken, 0);
    check("dma_rd_rdata", a_drdata, 24'h0ABCDE);
    a_dreq = 1'b0;
    tick();
    check("dma_rd_idle_ack", a_dack, 0);

    // Starvation: CPU wins 4 contended grants, DMA wins the 5th
    a_vpa = 1'b1; a_addr = 24'h000400;
    a_dreq = 1'b1; a_drnw = 1'b1; a_daddr = 24'h000300;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("starve_cpu%0d_maddr", i), a_maddr, 24'h000400);
      check($sformatf("starve_cpu%0d_ack", i), a_dack, 0);
      tick();
    end
    tick();
    check("starve_dma_maddr", a_maddr, 24'h000300);
    check("starve_dma_ack", a_dack, 1);
    check("starve_dma_clken", a_clken, 0);
    check("starve_cnt_clear", u_dut_a.u_pick.r_starve_cnt, 0);
    tick();
    tick();
    check("starve_after_cpu", a_maddr, 24'h000400);
    check("starve_after_ack", a_dack, 0);
    a_vpa = 1'b0; a_dreq = 1'b0;
    tick();

`ifdef OPC8_ARB_DMA_BURST_EN
    // Read burst from FFFFFE wrapping through 000000
    a_burst = 1'b1; a_dreq = 1'b1; a_drnw = 1'b1; a_daddr = 24'hFFFFFE;
    tick();
    check("burst0_maddr", a_maddr, 24'hFFFFFE);
    check("burst0_ack", a_dack, 1);
    check("burst0_ce", a_ce, 1);
    tick();
    check("burst1_maddr", a_maddr, 24'hFFFFFF);
    check("burst1_ack", a_dack, 1);
    tick();
    check("burst2_maddr", a_maddr, 24'h000000);
    check("burst2_ack", a_dack, 1);
    a_dreq = 1'b0;
    #1;
    tick();
    check("burst_end_state", u_dut_a.r_state, IDLE);
    check("burst_end_ack", a_dack, 0);
    check("burst_end_ce", a_ce, 0);
    a_burst = 1'b0;
`endif

    // MEM_LAT=2 DMA write to FFFFFF
    b_dreq = 1'b1; b_drnw = 1'b0; b_daddr = 24'hFFFFFF; b_dwdata = 24'h00ABCD;
    #1;
    check("l2_idle_clken", b_clken, 1);
    tick();
    check("l2_dwr_ce0", b_ce, 1);
    check("l2_dwr_we", b_we, 1);
    check("l2_dwr_maddr", b_maddr, 24'hFFFFFF);
    check("l2_dwr_wdata", b_mwdata, 24'h00ABCD);
    check("l2_dwr_ack0", b_dack, 0);
    check("l2_dwr_clken0", b_clken, 0);
    tick();
    check("l2_dwr_ce1", b_ce, 0);
    check("l2_dwr_ack1", b_dack, 1);
    check("l2_dwr_clken1", b_clken, 0);
    check("l2_dwr_maddr1", b_maddr, 24'hFFFFFF);
    b_dreq = 1'b0;
    tick();
    check("l2_dwr_idle_ack", b_dack, 0);

    // MEM_LAT=2 CPU read: clken 0,0,1
    b_vpa = 1'b1; b_rnw = 1'b1; b_addr = 24'h000020; b_mrdata = 24'h654321;
    tick();
    check("l2_crd_clken0", b_clken, 0);
    check("l2_crd_ce0", b_ce, 1);
    tick();
    check("l2_crd_clken1", b_clken, 1);
    check("l2_crd_din", b_din, 24'h654321);
    check("l2_crd_ce1", b_ce, 0);
    tick();

    // Reset asserted mid CPU_BUS
    tick();
    check("l2_mid_ce", b_ce, 1);
    b_reset_b = 1'b0;
    #1;
    check("l2_rst_hold_clken", b_clken, 1);
    check("l2_rst_hold_ack", b_dack, 0);
    tick();
    check("l2_rst_state", u_dut_b.r_state, IDLE);
    check("l2_rst_clken", b_clken, 1);
    check("l2_rst_ce", b_ce, 0);
    check("l2_rst_ack", b_dack, 0);
    check("l2_rst_maddr", b_maddr, 0);
    b_reset_b = 1'b1; b_vpa = 1'b0;
    #1;
    check("l2_post_rst_clken", b_clken, 1);
    tick();
    check("l2_post_rst_state", u_dut_b.r_state, IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
